reg_status_table: RTL and testbench

- Parametrised Tomasulo register status table and architectural register file: tracks, per register, the reservation-station tag (Qi) that will produce its next value, and holds committed values.
- Sits between the dispatch unit, which reads source operands and claims destinations, and the CDB, which broadcasts results.
- Generalises the fixed 4-register table:
  - configurable register, station and data widths;
  - tag-matched CDB writeback, so stale producers cannot overwrite a newer claim (WAW-safe);
  - two CDB-bypassed source read ports;
  - flush;
  - busy-register counter.

---
 rtl/reg_status_table_pkg.sv | 21 ++
 rtl/reg_status_table_rst_entry.sv | 59 +++++
 rtl/reg_status_table.sv | 119 +++++++++++
 tb/tb_reg_status_table.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/reg_status_table_pkg.sv
// Shared constants for the Tomasulo register status table and the reservation stations.
// Tag 0 means "no producer"; architectural registers 0..3 come out of reset as 2,4,3,5.
package reg_status_pkg;

  localparam int RS_TAG_W = 3;

  localparam logic [RS_TAG_W-1:0] TAG_FREE   = '0;
  localparam logic [RS_TAG_W-1:0] NO_STATION = '0;
  localparam logic [15:0]         NO_VALUE   = 16'hFFF0;

  function automatic int unsigned reset_value(input int unsigned idx);
    case (idx)
      0:       return 2;
      1:       return 4;
      2:       return 3;
      3:       return 5;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/reg_status_table_rst_entry.sv
// One architectural register: producer tag (Qi) plus committed value.
// Exposes qi_next so the parent can count busy registers after this edge's update.
module rst_entry
  import reg_status_pkg::*;
#(
  parameter int                DATA_W    = 16,
  parameter int                TAG_W     = RS_TAG_W,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  input  logic              claim,
  input  logic [TAG_W-1:0]  disp_tag,
  input  logic              flush,
  output logic [TAG_W-1:0]  qi,
  output logic [TAG_W-1:0]  qi_next,
  output logic [DATA_W-1:0] data
);

  logic [TAG_W-1:0]  qi_q, qi_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              cdb_match;

  // Only the current owner's broadcast may retire this register (WAW safety).
  assign cdb_match = cdb_valid && (cdb_tag != TAG_W'(TAG_FREE)) && (qi_q == cdb_tag);

  always_comb begin
    data_d = data_q;
    qi_d   = qi_q;
    if (cdb_match) begin
      data_d = cdb_data;
      qi_d   = TAG_W'(TAG_FREE);
    end
    if (claim) begin
      qi_d = disp_tag;
    end
    if (flush) begin
      qi_d = TAG_W'(TAG_FREE);
    end
  end

  always_ff @(negedge Clock or posedge Reset) begin
    if (Reset) begin
      qi_q   <= TAG_W'(TAG_FREE);
      data_q <= RESET_VAL;
    end else begin
      qi_q   <= qi_d;
      data_q <= data_d;
    end
  end

  assign qi      = qi_q;
  assign qi_next = qi_d;
  assign data    = data_q;

endmodule

// File: rtl/reg_status_table.sv
// Tomasulo register status table + architectural register file with CDB-bypassed
// source reads, tag-matched writeback, flush, per-station finish pulses and busy count.
module reg_status_table
  import reg_status_pkg::*;
#(
  parameter  int NUM_REGS = 4,
  parameter  int DATA_W   = 16,
  parameter  int TAG_W    = RS_TAG_W,
  parameter  int NUM_RS   = 4,
  localparam int IDX_W    = $clog2(NUM_REGS)
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  input  logic              disp_valid,
  input  logic [IDX_W-1:0]  disp_rd,
  input  logic [TAG_W-1:0]  disp_tag,
  input  logic              flush,
  input  logic [IDX_W-1:0]  rs1_idx,
  input  logic [IDX_W-1:0]  rs2_idx,
  output logic [TAG_W-1:0]  rs1_qi,
  output logic [TAG_W-1:0]  rs2_qi,
  output logic [DATA_W-1:0] rs1_val,
  output logic [DATA_W-1:0] rs2_val,
  output logic [NUM_RS-1:0] finished,
  output logic [IDX_W:0]    busy_count
);

  logic [TAG_W-1:0]  qi_arr      [NUM_REGS];
  logic [TAG_W-1:0]  qi_next_arr [NUM_REGS];
  logic [DATA_W-1:0] data_arr    [NUM_REGS];
  logic              disp_ok;

  assign disp_ok = disp_valid && (disp_tag != TAG_W'(TAG_FREE));

  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_entry
      rst_entry #(
        .DATA_W    (DATA_W),
        .TAG_W     (TAG_W),
        .RESET_VAL (DATA_W'(reset_value(gi)))
      ) u_entry (
        .Clock     (Clock),
        .Reset     (Reset),
        .cdb_valid (cdb_valid),
        .cdb_tag   (cdb_tag),
        .cdb_data  (cdb_data),
        .claim     (disp_ok && (disp_rd == IDX_W'(gi))),
        .disp_tag  (disp_tag),
        .flush     (flush),
        .qi        (qi_arr[gi]),
        .qi_next   (qi_next_arr[gi]),
        .data      (data_arr[gi])
      );
    end
  endgenerate

  logic [IDX_W-1:0]  rd_idx [2];
  logic [TAG_W-1:0]  rd_qi  [2];
  logic [DATA_W-1:0] rd_val [2];

  assign rd_idx[0] = rs1_idx;
  assign rd_idx[1] = rs2_idx;

  // Reads see the in-flight CDB result but never a same-cycle dispatch claim.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_qi[p]  = '0;
      rd_val[p] = '0;
      if (int'(rd_idx[p]) < NUM_REGS) begin
        rd_qi[p]  = qi_arr[rd_idx[p]];
        rd_val[p] = data_arr[rd_idx[p]];
        if ((rd_qi[p] != TAG_W'(TAG_FREE)) && cdb_valid && (cdb_tag == rd_qi[p])) begin
          rd_qi[p]  = TAG_W'(TAG_FREE);
          rd_val[p] = cdb_data;
        end
      end
    end
  end

  assign rs1_qi  = rd_qi[0];
  assign rs1_val = rd_val[0];
  assign rs2_qi  = rd_qi[1];
  assign rs2_val = rd_val[1];

  logic [NUM_RS-1:0] finished_q, finished_d;
  logic [IDX_W:0]    busy_count_q, busy_count_d;

  // Stations pulse on their own broadcast even when no register still points at them.
  always_comb begin
    finished_d = '0;
    for (int k = 0; k < NUM_RS; k++) begin
      finished_d[k] = cdb_valid && (cdb_tag == TAG_W'(k + 1));
    end
  end

  always_comb begin
    busy_count_d = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      busy_count_d = busy_count_d + (IDX_W+1)'(qi_next_arr[k] != TAG_W'(TAG_FREE));
    end
  end

  always_ff @(negedge Clock or posedge Reset) begin
    if (Reset) begin
      finished_q   <= '0;
      busy_count_q <= '0;
    end else begin
      finished_q   <= finished_d;
      busy_count_q <= busy_count_d;
    end
  end

  assign finished   = finished_q;
  assign busy_count = busy_count_q;

endmodule

// File: tb/tb_reg_status_table.sv
// Directed bench: a default-size table driven from a vector table, plus a wide
// 8-register/6-station instance exercised with hand-written sequences.
module tb_reg_status_table;

  logic        Clock;
  logic        Reset;

  logic        cdb_valid, disp_valid, flush;
  logic [2:0]  cdb_tag, disp_tag;
  logic [15:0] cdb_data;
  logic [1:0]  disp_rd, rs1_idx, rs2_idx;
  logic [2:0]  rs1_qi, rs2_qi;
  logic [15:0] rs1_val, rs2_val;
  logic [3:0]  finished;
  logic [2:0]  busy_count;

  logic        b_cdb_valid, b_disp_valid, b_flush;
  logic [2:0]  b_cdb_tag, b_disp_tag;
  logic [31:0] b_cdb_data;
  logic [2:0]  b_disp_rd, b_rs1_idx, b_rs2_idx;
  logic [2:0]  b_rs1_qi, b_rs2_qi;
  logic [31:0] b_rs1_val, b_rs2_val;
  logic [5:0]  b_finished;
  logic [3:0]  b_busy_count;

  int total  = 0;
  int passed = 0;

  reg_status_table dut (
    .Clock(Clock), .Reset(Reset),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .disp_valid(disp_valid), .disp_rd(disp_rd), .disp_tag(disp_tag),
    .flush(flush), .rs1_idx(rs1_idx), .rs2_idx(rs2_idx),
    .rs1_qi(rs1_qi), .rs2_qi(rs2_qi), .rs1_val(rs1_val), .rs2_val(rs2_val),
    .finished(finished), .busy_count(busy_count)
  );

  reg_status_table #(.NUM_REGS(8), .DATA_W(32), .TAG_W(3), .NUM_RS(6)) dut_b (
    .Clock(Clock), .Reset(Reset),
    .cdb_valid(b_cdb_valid), .cdb_tag(b_cdb_tag), .cdb_data(b_cdb_data),
    .disp_valid(b_disp_valid), .disp_rd(b_disp_rd), .disp_tag(b_disp_tag),
    .flush(b_flush), .rs1_idx(b_rs1_idx), .rs2_idx(b_rs2_idx),
    .rs1_qi(b_rs1_qi), .rs2_qi(b_rs2_qi), .rs1_val(b_rs1_val), .rs2_val(b_rs2_val),
    .finished(b_finished), .busy_count(b_busy_count)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin
    #50000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic        cv;
    logic [2:0]  ct;
    logic [15:0] cd;
    logic        dv;
    logic [1:0]  drd;
    logic [2:0]  dt;
    logic        fl;
    logic [1:0]  i1, i2;
    logic [2:0]  q1;
    logic [15:0] v1;
    logic [2:0]  q2;
    logic [15:0] v2;
    logic [3:0]  fin;
    logic [2:0]  busy;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic cv, input logic [2:0] ct, input logic [15:0] cd,
                     input logic dv, input logic [1:0] drd, input logic [2:0] dt,
                     input logic fl, input logic [1:0] i1, input logic [1:0] i2,
                     input logic [2:0] q1, input logic [15:0] v1,
                     input logic [2:0] q2, input logic [15:0] v2,
                     input logic [3:0] fin, input logic [2:0] busy);
    vec_t v;
    v.cv = cv; v.ct = ct; v.cd = cd; v.dv = dv; v.drd = drd; v.dt = dt; v.fl = fl;
    v.i1 = i1; v.i2 = i2; v.q1 = q1; v.v1 = v1; v.q2 = q2; v.v2 = v2;
    v.fin = fin; v.busy = busy;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    else passed++;
  endtask

  task automatic idle_a();
    cdb_valid = 0; cdb_tag = 0; cdb_data = 0;
    disp_valid = 0; disp_rd = 0; disp_tag = 0; flush = 0;
  endtask

  task automatic idle_b();
    b_cdb_valid = 0; b_cdb_tag = 0; b_cdb_data = 0;
    b_disp_valid = 0; b_disp_rd = 0; b_disp_tag = 0; b_flush = 0;
  endtask

  initial begin
    Reset = 1'b1;
    idle_a(); idle_b();
    rs1_idx = 0; rs2_idx = 0; b_rs1_idx = 3; b_rs2_idx = 4;

    //   cv ct cd        dv rd dt fl  i1 i2  q1 v1       q2 v2       fin busy
    add(0, 0, 0,         0, 0, 0, 0,  0, 1,  0, 2,       0, 4,       0, 0);
    add(0, 0, 0,         0, 0, 0, 0,  2, 3,  0, 3,       0, 5,       0, 0);
    add(0, 0, 0,         1, 2, 1, 0,  2, 2,  0, 3,       0, 3,       0, 1);
    add(0, 0, 0,         0, 0, 0, 0,  2, 0,  1, 3,       0, 2,       0, 1);
    add(1, 1, 16'h0009,  0, 0, 0, 0,  2, 1,  0, 9,       0, 4,       1, 0);
    add(0, 0, 0,         0, 0, 0, 0,  2, 3,  0, 9,       0, 5,       0, 0);
    add(0, 0, 0,         1, 1, 1, 0,  1, 0,  0, 4,       0, 2,       0, 1);
    add(0, 0, 0,         1, 1, 2, 0,  1, 0,  1, 4,       0, 2,       0, 1);
    add(1, 1, 16'h0007,  0, 0, 0, 0,  1, 0,  2, 4,       0, 2,       1, 1);
    add(1, 2, 16'h0008,  0, 0, 0, 0,  1, 2,  0, 8,       0, 9,       2, 0);
    add(0, 0, 0,         0, 0, 0, 0,  1, 0,  0, 8,       0, 2,       0, 0);
    add(0, 0, 0,         1, 3, 2, 0,  3, 0,  0, 5,       0, 2,       0, 1);
    add(1, 2, 16'h0055,  1, 3, 3, 0,  3, 0,  0, 16'h55,  0, 2,       2, 1);
    add(0, 0, 0,         0, 0, 0, 0,  3, 0,  3, 16'h55,  0, 2,       0, 1);
    add(0, 0, 0,         1, 0, 1, 0,  0, 3,  0, 2,       3, 16'h55,  0, 2);
    add(0, 0, 0,         1, 2, 4, 0,  0, 2,  1, 2,       0, 9,       0, 3);
    add(0, 0, 0,         1, 1, 2, 1,  2, 0,  4, 9,       1, 2,       0, 0);
    add(0, 0, 0,         0, 0, 0, 0,  0, 2,  0, 2,       0, 9,       0, 0);
    add(0, 0, 0,         1, 1, 3, 0,  1, 0,  0, 8,       0, 2,       0, 1);
    add(1, 3, 16'h1234,  0, 0, 0, 1,  1, 0,  0, 16'h1234, 0, 2,      4, 0);
    add(0, 0, 0,         0, 0, 0, 0,  1, 3,  0, 16'h1234, 0, 16'h55, 0, 0);
    add(1, 0, 16'hBEEF,  0, 0, 0, 0,  0, 1,  0, 2,       0, 16'h1234, 0, 0);
    add(0, 0, 0,         1, 0, 0, 0,  0, 1,  0, 2,       0, 16'h1234, 0, 0);
    add(1, 5, 16'hDEAD,  0, 0, 0, 0,  2, 3,  0, 9,       0, 16'h55,  0, 0);
    add(0, 0, 0,         1, 0, 2, 0,  0, 2,  0, 2,       0, 9,       0, 1);
    add(0, 0, 0,         1, 2, 2, 0,  0, 2,  2, 2,       0, 9,       0, 2);
    add(1, 2, 16'h0077,  0, 0, 0, 0,  0, 2,  0, 16'h77,  0, 16'h77,  2, 0);
    add(0, 0, 0,         0, 0, 0, 0,  0, 2,  0, 16'h77,  0, 16'h77,  0, 0);

    repeat (2) @(negedge Clock);
    #1;
    chk("reset finished", 64'(finished), 64'h0);
    chk("reset busy_count", 64'(busy_count), 64'h0);
    chk("b reset rs1_val", 64'(b_rs1_val), 64'd5);
    chk("b reset rs2_val", 64'(b_rs2_val), 64'd0);
    chk("b reset rs2_qi", 64'(b_rs2_qi), 64'd0);
    @(posedge Clock); #1 Reset = 1'b0;
    @(negedge Clock); #1;

    for (int i = 0; i < vecs.size(); i++) begin
      cdb_valid = vecs[i].cv; cdb_tag = vecs[i].ct; cdb_data = vecs[i].cd;
      disp_valid = vecs[i].dv; disp_rd = vecs[i].drd; disp_tag = vecs[i].dt;
      flush = vecs[i].fl; rs1_idx = vecs[i].i1; rs2_idx = vecs[i].i2;
      @(posedge Clock); #1;
      chk($sformatf("v%0d rs1_qi", i), 64'(rs1_qi), 64'(vecs[i].q1));
      chk($sformatf("v%0d rs1_val", i), 64'(rs1_val), 64'(vecs[i].v1));
      chk($sformatf("v%0d rs2_qi", i), 64'(rs2_qi), 64'(vecs[i].q2));
      chk($sformatf("v%0d rs2_val", i), 64'(rs2_val), 64'(vecs[i].v2));
      @(negedge Clock); #1;
      chk($sformatf("v%0d finished", i), 64'(finished), 64'(vecs[i].fin));
      chk($sformatf("v%0d busy_count", i), 64'(busy_count), 64'(vecs[i].busy));
      $display("vec %0d: cdb=%0b/%0d/%h disp=%0b/%0d/%0d flush=%0b -> fin=%b busy=%0d",
               i, vecs[i].cv, vecs[i].ct, vecs[i].cd, vecs[i].dv, vecs[i].drd,
               vecs[i].dt, vecs[i].fl, finished, busy_count);
    end
    idle_a();

    // Wide instance: claim r7 with station 6, then an out-of-range tag 7.
    b_disp_valid = 1; b_disp_rd = 7; b_disp_tag = 6; b_rs1_idx = 7;
    @(negedge Clock); #1;
    idle_b();
    chk("b claim busy_count", 64'(b_busy_count), 64'd1);
    chk("b claim rs1_qi", 64'(b_rs1_qi), 64'd6);
    $display("b: dispatch r7 tag6 -> busy=%0d", b_busy_count);
    b_cdb_valid = 1; b_cdb_tag = 7; b_cdb_data = 32'hCAFEF00D;
    @(negedge Clock); #1;
    idle_b();
    chk("b tag7 finished", 64'(b_finished), 64'h0);
    chk("b tag7 busy_count", 64'(b_busy_count), 64'd1);
    $display("b: cdb tag7 -> fin=%b busy=%0d", b_finished, b_busy_count);
    b_cdb_valid = 1; b_cdb_tag = 6; b_cdb_data = 32'hA5A50001;
    @(posedge Clock); #1;
    chk("b bypass rs1_qi", 64'(b_rs1_qi), 64'd0);
    chk("b bypass rs1_val", 64'(b_rs1_val), 64'hA5A50001);
    @(negedge Clock); #1;
    idle_b();
    chk("b tag6 finished", 64'(b_finished), 64'h20);
    chk("b tag6 busy_count", 64'(b_busy_count), 64'd0);
    chk("b r7 value", 64'(b_rs1_val), 64'hA5A50001);
    $display("b: cdb tag6 -> fin=%b busy=%0d", b_finished, b_busy_count);

    // Build state in both instances, then assert reset between edges.
    disp_valid = 1; disp_rd = 1; disp_tag = 1; cdb_valid = 1; cdb_tag = 3; rs1_idx = 1;
    b_disp_valid = 1; b_disp_rd = 5; b_disp_tag = 3; b_rs1_idx = 5;
    @(negedge Clock); #1;
    idle_a(); idle_b();
    chk("pre-reset finished", 64'(finished), 64'h4);
    chk("pre-reset busy_count", 64'(busy_count), 64'd1);
    chk("pre-reset rs1_qi", 64'(rs1_qi), 64'd1);
    chk("b pre-reset busy_count", 64'(b_busy_count), 64'd1);
    @(posedge Clock); #1;
    Reset = 1'b1;
    #1;
    chk("async reset finished", 64'(finished), 64'h0);
    chk("async reset busy_count", 64'(busy_count), 64'd0);
    chk("async reset rs1_qi", 64'(rs1_qi), 64'd0);
    chk("async reset rs1_val", 64'(rs1_val), 64'd4);
    chk("b async reset busy_count", 64'(b_busy_count), 64'd0);
    chk("b async reset rs1_qi", 64'(b_rs1_qi), 64'd0);
    $display("async reset mid-cycle -> fin=%b busy=%0d b_busy=%0d", finished, busy_count, b_busy_count);
    #1 Reset = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
